// File: rtl/hazard_ctrl.sv
// hazard_ctrl: PC/IF-ID/ID-EX stall, flush and bubble control for the 5-stage MIPS core,
// with mult/div busy interlock, imem timeout detection and a saturating stall counter.
module hazard_ctrl #(
  parameter int MD_LAT       = 32,
  parameter int IMEM_TIMEOUT = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_uses_hilo,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             md_start,
  input  logic             branch_taken,
  input  logic             imem_ready,
  output logic             pc_we,
  output logic             if_id_ld,
  output logic             if_id_clr,
  output logic             id_ex_clr,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             imem_err,
  output logic             md_err
);
  localparam int MW = $clog2(MD_LAT + 1);
  localparam int IW = $clog2(IMEM_TIMEOUT + 1);

  logic [MW-1:0]    md_cnt_q, md_cnt_d;
  logic [IW-1:0]    imiss_q, imiss_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             imem_err_q, imem_err_d, md_err_q, md_err_d;
  logic             load_use, md_hazard, stall_id;

  assign md_busy      = md_cnt_q != '0;
  assign stall_cycles = stall_q;
  assign imem_err     = imem_err_q;
  assign md_err       = md_err_q;

  always_comb begin
    load_use   = ex_mem_read & (ex_rt != 5'd0) &
                 ((id_uses_rs & (ex_rt == id_rs)) | (id_uses_rt & (ex_rt == id_rt)));
    md_hazard  = id_uses_hilo & (md_busy | md_start);
    stall_id   = load_use | md_hazard;
    md_cnt_d   = (md_start && !md_busy) ? MW'(MD_LAT) : md_busy ? md_cnt_q - MW'(1) : md_cnt_q;
    imiss_d    = imem_ready ? '0 : (imiss_q == IW'(IMEM_TIMEOUT)) ? imiss_q : imiss_q + IW'(1);
    stall_d    = (stall_id && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
    imem_err_d = imem_err_q | (imiss_d == IW'(IMEM_TIMEOUT));
    md_err_d   = md_err_q | (md_start & md_busy);
    // stall masks the branch: the ID instruction that resolved it is not valid yet
    pc_we      = rst & ~stall_id & (branch_taken | imem_ready);
    if_id_ld   = rst & ~stall_id;
    if_id_clr  = rst & ~stall_id & (branch_taken | ~imem_ready);
    id_ex_clr  = rst & stall_id;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      md_cnt_q   <= '0;
      imiss_q    <= '0;
      stall_q    <= '0;
      imem_err_q <= 1'b0;
      md_err_q   <= 1'b0;
    end else begin
      md_cnt_q   <= md_cnt_d;
      imiss_q    <= imiss_d;
      stall_q    <= stall_d;
      imem_err_q <= imem_err_d;
      md_err_q   <= md_err_d;
    end
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage MIPS core.
- Drives PC write-enable, the IF/ID register's load and clear inputs, and the ID/EX bubble.
- Resolves load-use hazards, multiply/divide busy interlocks, taken-branch flushes and instruction-memory wait states.
- Keeps a stall performance counter and sticky error flags.

Parameters:
- MD_LAT, 32, mult/div unit busy cycles after issue (≥1)
- IMEM_TIMEOUT, 16, consecutive imem-not-ready cycles before imem_err is set (≥1)
- CNT_W, 32, width of the stall_cycles counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_uses_hilo  in  1  ID instruction is MFHI/MFLO/MTHI/MTLO or MULT/DIV
- ex_mem_read  in  1  EX instruction is a load
- ex_rt  in  5  destination register of EX load
- md_start  in  1  mult/div issued from EX this cycle
- branch_taken  in  1  branch/jump resolved taken in ID
- imem_ready  in  1  instruction memory returns valid data this cycle
- pc_we  out  1  PC register write enable
- if_id_ld  out  1  IF/ID load control, wired to the IF/ID register's stall port: 1 = load, 0 = hold
- if_id_clr  out  1  IF/ID synchronous clear (bubble)
- id_ex_clr  out  1  ID/EX synchronous clear (bubble)
- md_busy  out  1  mult/div unit busy
- stall_cycles  out  CNT_W  saturating count of stall_id cycles
- imem_err  out  1  sticky instruction-fetch timeout
- md_err  out  1  sticky md_start-while-busy

Behaviour:
- Reset (rst low, async): md_cnt=0, imiss_cnt=0, stall_cycles=0, imem_err=0, md_err=0.
- While rst is low, all control outputs are forced to 0.

Hazard terms (combinational):
- load_use = ex_mem_read & (ex_rt!=0) & ((id_uses_rs & ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- md_busy = (md_cnt != 0).
- md_hazard = id_uses_hilo & (md_busy | md_start).
- stall_id = load_use | md_hazard.

Control outputs, combinational, first matching rule wins:
1. stall_id: pc_we=0, if_id_ld=0, if_id_clr=0, id_ex_clr=1. branch_taken is masked, because the ID instruction is not yet valid.
2. branch_taken: pc_we=1, if_id_ld=1, if_id_clr=1, id_ex_clr=0.
3. !imem_ready: pc_we=0, if_id_ld=1, if_id_clr=1, id_ex_clr=0. This inserts a bubble into ID.
4. Otherwise: pc_we=1, if_id_ld=1, if_id_clr=0, id_ex_clr=0.

MD counter:
- On md_start with md_cnt==0: md_cnt <= MD_LAT at the clock edge.
- Else if md_cnt!=0: decrement by 1 each cycle.
- md_start while md_cnt!=0: no reload, md_err <= 1 (sticky).
- A dependent instruction in ID alongside md_start therefore stalls for exactly MD_LAT+1 cycles.

IMEM timeout:
- imiss_cnt increments, saturating, on each cycle with !imem_ready; it clears when imem_ready=1.
- When imiss_cnt reaches IMEM_TIMEOUT: imem_err <= 1 (sticky until reset).
- The pipeline keeps waiting; no recovery action is taken.

Stall counter:
- stall_cycles increments on each cycle with stall_id=1.
- It saturates at all-ones, with no wrap.

Simultaneous events:
- load_use and md_hazard together: a single stall. The stall persists while either term is true.
- branch_taken together with !imem_ready: the flush wins (rule 2) and PC loads the target.

Reset mid-operation: md_cnt and all flags clear immediately; outputs go to 0 without waiting for a clock edge.

Test Plan:
- ex_mem_read=1, ex_rt=8, id_rs=8, id_uses_rs=1 for one cycle -> that cycle pc_we=0, if_id_ld=0, id_ex_clr=1; stall_cycles 0->1. With ex_rt=0 -> no stall.
- md_start=1 at cycle 0 with MD_LAT=4, id_uses_hilo=1 held -> stall_id high cycles 0-4 (5 cycles); md_busy high cycles 1-4; normal flow at cycle 5.
- branch_taken=1 with no hazard -> pc_we=1, if_id_clr=1. Same with load_use=1 -> flush masked, stall outputs only.
- imem_ready=0 for 3 cycles, IMEM_TIMEOUT=16 -> pc_we=0, if_id_clr=1 each cycle, imem_err stays 0. Holding low for 16 cycles -> imem_err=1 and it stays 1 after imem_ready returns.
- md_start pulsed at cycles 0 and 2, MD_LAT=4 -> md_err=1 and md_busy falls after cycle 4 (no reload).
- Assert rst low mid-MD_WAIT at md_cnt=3 -> md_busy=0, all outputs 0 and stall_cycles=0 immediately. After release, normal flow (pc_we=1, if_id_ld=1).
